counter_down_timer: RTL and testbench

//   Loadable synchronous down-counter/timer; the count-down counterpart of the up counters in
//   the sync counter library. Holds a reload value and decrements count_out on each en_in

---
 rtl/counter_down_timer_pkg.sv | 13 +
 rtl/counter_down_core.sv | 31 +++
 rtl/counter_down_timer.sv | 106 ++++++++++
 tb/tb_counter_down_timer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_down_timer_pkg.sv
// Shared definitions for the down-counter/timer: FSM state encodings
// (IDLE = 0, RUN = 1, DONE = 2, the same values the other counter FSMs use).
package counter_down_timer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/counter_down_core.sv
// Datapath for the down-counter: a loadable register that can step down
// by one. It refuses to step below zero, so the count never wraps to all-ones.
// A load has priority over a decrement.
module counter_down_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Count register: reset clears, load overrides, dec steps down with a zero floor
  always_ff @(posedge clk) begin
    if (reset_in) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign is_one = (count == ONE);

endmodule

// File: rtl/counter_down_timer.sv
// Loadable down-counter/timer. Holds a reload value, counts down on en_in
// ticks while running, and pulses tc_out for one cycle at terminal count.
// It then stops in DONE (one-shot) or reloads and keeps running (periodic).
module counter_down_timer
  import counter_down_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load_in,
  input  logic             start_in,
  input  logic             en_in,
  input  logic             auto_reload_in,
  output logic [WIDTH-1:0] count_out,
  output logic             tc_out,
  output logic             busy_out,
  output logic             done_out
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] reload;
  logic             tc_nxt;
  logic             core_load;
  logic [WIDTH-1:0] core_val;
  logic             core_dec;
  logic             is_one;

  counter_down_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .reset_in (reset_in),
    .load     (core_load),
    .load_val (core_val),
    .dec      (core_dec),
    .count    (count_out),
    .is_one   (is_one)
  );

  // Next-state and datapath control; priority is load > start > en tick
  always_comb begin
    state_nxt = state;
    core_load = 1'b0;
    core_val  = reload;
    core_dec  = 1'b0;
    tc_nxt    = 1'b0;
    if (load_in) begin
      // A load aborts any run silently and parks the timer in IDLE
      state_nxt = ST_IDLE;
      core_load = 1'b1;
      core_val  = d_in;
    end else if (start_in && (state != ST_RUN)) begin
      core_load = 1'b1;
      core_val  = reload;
      if (reload == '0) begin
        // Zero-length timer: terminal count is immediate
        state_nxt = ST_DONE;
        tc_nxt    = 1'b1;
      end else begin
        state_nxt = ST_RUN;
      end
    end else if ((state == ST_RUN) && en_in) begin
      if (is_one) begin
        tc_nxt = 1'b1;
        if (auto_reload_in) begin
          core_load = 1'b1;
          core_val  = reload;
        end else begin
          core_dec  = 1'b1;
          state_nxt = ST_DONE;
        end
      end else begin
        core_dec = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Reload register and one-cycle terminal-count pulse
  always_ff @(posedge clk) begin
    if (reset_in) begin
      reload <= '0;
      tc_out <= 1'b0;
    end else begin
      tc_out <= tc_nxt;
      if (load_in) begin
        reload <= d_in;
      end
    end
  end

  assign busy_out = (state == ST_RUN);
  assign done_out = (state == ST_DONE);

endmodule

// File: tb/tb_counter_down_timer.sv
// Testbench for counter_down_timer: a directed vector table, hand-written
// corner sequences and randomized traffic checked against a behavioural model.
module tb_counter_down_timer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset_in;
  logic [WIDTH-1:0] d_in;
  logic             load_in;
  logic             start_in;
  logic             en_in;
  logic             auto_reload_in;
  logic [WIDTH-1:0] count_out;
  logic             tc_out;
  logic             busy_out;
  logic             done_out;

  always #5 clk = ~clk;

  counter_down_timer #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .reset_in       (reset_in),
    .d_in           (d_in),
    .load_in        (load_in),
    .start_in       (start_in),
    .en_in          (en_in),
    .auto_reload_in (auto_reload_in),
    .count_out      (count_out),
    .tc_out         (tc_out),
    .busy_out       (busy_out),
    .done_out       (done_out)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: timer described by its visible count, stored reload
  // value, whether it is running / finished, and the pulse owed this cycle.
  int m_count;
  int m_reload;
  bit m_running;
  bit m_finished;
  bit m_tc;

  typedef struct {
    bit             rst;
    bit             ld;
    logic [WIDTH-1:0] d;
    bit             st;
    bit             en;
    bit             ar;
    int             count;
    bit             tc;
    bit             busy;
    bit             done;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit ld, input int d, input bit st,
                       input bit en, input bit ar);
    reset_in       = rst;
    load_in        = ld;
    d_in           = d[WIDTH-1:0];
    start_in       = st;
    en_in          = en;
    auto_reload_in = ar;
  endtask

  task automatic model_edge();
    m_tc = 1'b0;
    if (reset_in) begin
      m_count = 0; m_reload = 0; m_running = 0; m_finished = 0;
    end else if (load_in) begin
      m_reload = int'(d_in); m_count = int'(d_in);
      m_running = 0; m_finished = 0;
    end else if (start_in && !m_running) begin
      m_count = m_reload;
      if (m_reload == 0) begin
        m_finished = 1; m_tc = 1;
      end else begin
        m_running = 1; m_finished = 0;
      end
    end else if (m_running && en_in) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_tc = 1;
        if (auto_reload_in) m_count = m_reload;
        else begin
          m_running = 0; m_finished = 1;
        end
      end
    end
  endtask

  // One clock edge: advance the model, then compare away from the edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("count", int'(count_out), m_count);
    chk("tc", int'(tc_out), int'(m_tc));
    chk("busy", int'(busy_out), int'(m_running));
    chk("done", int'(done_out), int'(m_finished));
  endtask

  initial begin
    int ticks;
    bit got;
    bit seen_tc;

    drive(1, 0, 0, 0, 0, 0);
    m_count = 0; m_reload = 0; m_running = 0; m_finished = 0; m_tc = 0;

    //               rst ld  d     st en ar  cnt tc busy done
    tbl[0]  = '{1, 0, 8'd0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 8'd3, 0, 0, 0, 3, 0, 0, 0};
    tbl[2]  = '{0, 0, 8'd0, 1, 0, 0, 3, 0, 1, 0};
    tbl[3]  = '{0, 0, 8'd0, 0, 1, 0, 2, 0, 1, 0};
    tbl[4]  = '{0, 0, 8'd0, 0, 1, 0, 1, 0, 1, 0};
    tbl[5]  = '{0, 0, 8'd0, 0, 1, 0, 0, 1, 0, 1};
    tbl[6]  = '{0, 0, 8'd0, 0, 1, 0, 0, 0, 0, 1};
    tbl[7]  = '{0, 1, 8'd4, 1, 0, 0, 4, 0, 0, 0};
    tbl[8]  = '{0, 0, 8'd0, 1, 0, 1, 4, 0, 1, 0};
    tbl[9]  = '{0, 0, 8'd0, 0, 1, 1, 3, 0, 1, 0};
    tbl[10] = '{0, 0, 8'd0, 0, 1, 1, 2, 0, 1, 0};
    tbl[11] = '{0, 0, 8'd0, 0, 1, 1, 1, 0, 1, 0};
    tbl[12] = '{0, 0, 8'd0, 0, 1, 1, 4, 1, 1, 0};
    tbl[13] = '{0, 0, 8'd0, 1, 0, 1, 4, 0, 1, 0};
    tbl[14] = '{0, 0, 8'd0, 0, 1, 1, 3, 0, 1, 0};
    tbl[15] = '{0, 1, 8'd0, 0, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{0, 0, 8'd0, 1, 0, 0, 0, 1, 0, 1};
    tbl[17] = '{0, 0, 8'd0, 0, 0, 0, 0, 0, 0, 1};
    tbl[18] = '{0, 0, 8'd0, 1, 0, 0, 0, 1, 0, 1};

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst, tbl[i].ld, int'(tbl[i].d), tbl[i].st, tbl[i].en, tbl[i].ar);
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("tbl%0d_count", i), int'(count_out), tbl[i].count);
      chk($sformatf("tbl%0d_tc", i), int'(tc_out), int'(tbl[i].tc));
      chk($sformatf("tbl%0d_busy", i), int'(busy_out), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), int'(done_out), int'(tbl[i].done));
    end

    // Reset held two cycles in the middle of a run
    drive(0, 1, 10, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0);  tick();
    drive(0, 0, 0, 0, 1, 0);  tick(); tick();
    drive(1, 0, 0, 0, 1, 0);  tick();
    chk("rst_mid_count", int'(count_out), 0);
    chk("rst_mid_busy", int'(busy_out), 0);
    tick();
    chk("rst2_tc", int'(tc_out), 0);
    chk("rst2_done", int'(done_out), 0);

    // Gated enable: tick on every third cycle, terminal count on the 15th
    drive(0, 1, 5, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0); tick();
    for (int c = 1; c <= 15; c++) begin
      drive(0, 0, 0, 0, (c % 3) == 0, 0);
      tick();
      if (c < 15) chk("gated_early_tc", int'(tc_out), 0);
      else        chk("gated_tc_at_15", int'(tc_out), 1);
    end

    // Full-scale reload: 255 ticks, never wraps
    drive(0, 1, 255, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0);   tick();
    drive(0, 0, 0, 0, 1, 0);
    ticks = 0; got = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      tick();
      ticks++;
      if (tc_out) got = 1;
    end
    chk("max_ticks_to_tc", ticks, 255);
    tick();
    chk("max_no_wrap", int'(count_out), 0);

    // Load while running at count 2 aborts with no pulse
    drive(0, 1, 5, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0); tick(); tick(); tick();
    chk("abort_pre_count", int'(count_out), 2);
    drive(0, 1, 7, 0, 1, 0); tick();
    chk("abort_count", int'(count_out), 7);
    drive(0, 0, 0, 0, 1, 0);
    seen_tc = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (tc_out) seen_tc = 1;
    end
    chk("abort_no_tc", int'(seen_tc), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int dv;
      dv = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 6));
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0, dv,
            $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
